ps2_frame_gen: RTL

Synthesizable, parametrised PS/2 device-side frame generator. It replaces the behavioural scan-code sender used in keyboard-controller benches with a clocked block that can also drive hardware-in-the-loop stimulus. Scan-code bytes are queued in a small FIFO and serialised as 11-bit PS/2 frames: start, 8 data bits LSB first, parity, stop. Frame timing and parity sense are configurable, and break codes get an automatic `F0` prefix.

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_fifo.sv | 50 +++++
 rtl/ps2_frame_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types, constants and frame helpers for the PS/2 device-side
// frame generator.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PREFIX,
    SHIFT,
    GAP
  } state_t;

  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;

  function automatic logic ps2_parity(
    input logic [7:0] d,
    input logic       odd
  );
    return odd ? ~^d : ^d;
  endfunction

  // Bit 0 leaves the wire first: start, d[0]..d[7], parity, stop.
  function automatic logic [10:0] ps2_frame(
    input logic [7:0] d,
    input logic       odd
  );
    return {1'b1, ps2_parity(d, odd), d, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO holding {break, scan code} entries.
// FULL and COUNT are registered; a push while full is dropped.
module ps2_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_d;
  logic             push;
  logic             pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && (count != '0);
  assign count_d = count + CW'(push) - CW'(pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_frame_gen.sv
// PS/2 device-side frame generator: queues scan codes and serialises
// them as 11-bit frames, prefixing break entries with F0.
module ps2_frame_gen
  import ps2_pkg::*;
#(
  parameter int HALF_PERIOD = 8,
  parameter int DEPTH       = 4,
  parameter int PARITY_ODD  = 1,
  parameter int GAP_CYCLES  = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   WR_EN,
  input  logic [7:0]             WR_DATA,
  input  logic                   WR_BREAK,
  output logic                   FULL,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVF,
  output logic                   DATA,
  output logic                   PS2CLK,
  output logic                   BUSY,
  output logic                   FRAME_DONE
);

  localparam logic [8:0]  HP9       = 9'(HALF_PERIOD);
  localparam logic [8:0]  SLOT_LAST = 9'(2 * HALF_PERIOD - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(PS2_FRAME_BITS - 1);
  localparam logic        PODD      = (PARITY_ODD != 0);

  state_t      state;
  state_t      state_d;
  logic        pop;
  logic [8:0]  fifo_q;
  logic [8:0]  ent_q;
  logic [10:0] sr;
  logic [8:0]  scnt;
  logic [3:0]  bidx;
  logic [15:0] gcnt;
  logic        aft_pfx;
  logic        done_q;
  logic        sending;
  logic        slot_end;
  logic        frame_end;
  logic        load;

  ps2_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (WR_EN),
    .wr_data ({WR_BREAK, WR_DATA}),
    .rd_en   (pop),
    .rd_data (fifo_q),
    .full    (FULL),
    .count   (COUNT)
  );

  assign sending   = (state == SHIFT) || (state == PREFIX);
  assign slot_end  = (scnt == SLOT_LAST);
  assign frame_end = slot_end && (bidx == BIT_LAST);

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (COUNT != '0) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: state_d = ent_q[8] ? PREFIX : SHIFT;
      PREFIX: begin
        if (frame_end)
          state_d = (GAP_CYCLES == 0) ? SHIFT : GAP;
      end
      SHIFT: begin
        if (frame_end)
          state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gcnt == GAP_LAST)
          state_d = aft_pfx ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // A new frame starts whenever a sending state is freshly entered.
  assign load = (state_d == SHIFT || state_d == PREFIX)
                && (state_d != state);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ent_q   <= '0;
      sr      <= '1;
      scnt    <= '0;
      bidx    <= '0;
      gcnt    <= '0;
      aft_pfx <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= sending && frame_end;
      if (pop) ent_q <= fifo_q;
      if (load) begin
        sr   <= ps2_frame(state_d == PREFIX ? PS2_BREAK_CODE
                                            : ent_q[7:0], PODD);
        scnt <= '0;
        bidx <= '0;
      end else if (sending) begin
        scnt <= slot_end ? 9'd0 : scnt + 9'd1;
        if (slot_end) begin
          sr   <= {1'b1, sr[10:1]};
          bidx <= bidx + 4'd1;
        end
      end
      gcnt <= (state == GAP) ? gcnt + 16'd1 : 16'd0;
      if (state == PREFIX)     aft_pfx <= 1'b1;
      else if (state == SHIFT) aft_pfx <= 1'b0;
    end
  end

  assign DATA       = sending ? sr[0] : 1'b1;
  assign PS2CLK     = sending ? (scnt < HP9) : 1'b1;
  assign BUSY       = (state != IDLE);
  assign FRAME_DONE = done_q;
  assign OVF        = WR_EN && FULL;

endmodule
